mult_issue_ctrl: RTL and testbench

Operand front-end for the sequential signed multiplier. It buffers incoming operand pairs in a small FIFO and issues them one at a time with a single-cycle start pulse. It waits for the multiplier's ready, captures the 2*NB-bit product and presents it on a valid/ready output port, in order. It sits directly upstream of the multiplier and owns all handshaking toward it.

---
 rtl/mult_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - operand FIFO and issue/capture sequencer for the sequential signed multiplier
// Optional feature macro MULT_ISSUE_ZERO_SKIP_EN: zero-operand entries complete without starting the multiplier.
module mult_issue_ctrl #(
  parameter int NB         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NB-1:0]                 in_a,
  input  logic [NB-1:0]                 in_b,
  output logic                          mul_start,
  output logic [NB-1:0]                 mul_a,
  output logic [NB-1:0]                 mul_b,
  input  logic [2*NB-1:0]               mul_product,
  input  logic                          mul_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*NB-1:0]               out_product,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   L_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [NB-1:0]     r_mem_a [FIFO_DEPTH];
  logic [NB-1:0]     r_mem_b [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [NB-1:0]     r_mul_a, r_mul_b;
  logic              r_out_valid;
  logic [2*NB-1:0]   r_out_product;

  logic w_push, w_pop, w_load, w_capture;
  logic w_out_free, w_nonempty, w_head_zero, w_idle_block, w_zero_fire;

  assign in_ready    = (r_count != L_FULL);
  assign fifo_count  = r_count;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;

  assign w_push     = in_valid & in_ready;
  assign w_nonempty = (r_count != '0);
  assign w_out_free = ~r_out_valid | out_ready;

`ifdef MULT_ISSUE_ZERO_SKIP_EN
  logic r_zero_pend;

  // A skipped entry publishes its zero result one edge after the pop; hold off IDLE until then.
  assign w_head_zero  = (r_mem_a[r_rptr] == '0) | (r_mem_b[r_rptr] == '0);
  assign w_idle_block = r_zero_pend;
  assign w_zero_fire  = r_zero_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) r_zero_pend <= 1'b0;
    else        r_zero_pend <= w_pop & w_head_zero;
  end
`else
  assign w_head_zero  = 1'b0;
  assign w_idle_block = 1'b0;
  assign w_zero_fire  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    mul_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty && w_out_free && !w_idle_block) begin
          w_pop = 1'b1;
          if (!w_head_zero) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        mul_start   = 1'b1;
        w_state_nxt = S_ARM;
      end
      // mul_ready still reflects the previous operation here.
      S_ARM:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + L_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      if (w_load) begin
        r_mul_a <= r_mem_a[r_rptr];
        r_mul_b <= r_mem_b[r_rptr];
      end
      if (w_capture) begin
        r_out_valid   <= 1'b1;
        r_out_product <= mul_product;
      end else if (w_zero_fire) begin
        r_out_valid   <= 1'b1;
        r_out_product <= '0;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - self-checking bench for mult_issue_ctrl with a behavioural multiplier
module tb_mult_issue_ctrl;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_product = 16'hDEAD;
  logic        mul_ready = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.NB(NB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .fifo_count(fifo_count)
  );

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  // Multiplier: ready drops one edge after start, rises NB edges after start; product is junk meanwhile.
  int          m_cnt = 0;
  logic [15:0] m_pend = 16'h0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt  <= NB;
      m_pend <= smul(mul_a, mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == NB) begin
        mul_ready   <= 1'b0;
        mul_product <= 16'hDEAD;
      end
      if (m_cnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= m_pend;
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
    int          starts;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] sb_q[$];
  int n_checks = 0, n_pass = 0;
  int n_acc = 0, n_res = 0, n_starts = 0, n_ov = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    #1;
    if (!rst_n) sb_q.delete();
    else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(smul(in_a, in_b));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_res++;
        if (sb_q.size() == 0) chk("sb_unexpected_result", 32'(out_product), 32'hFFFF_FFFF);
        else                  chk("sb_product", 32'(out_product), 32'(sb_q.pop_front()));
      end
      if (mul_start) n_starts++;
      if (out_valid) n_ov++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_product"}, 32'(out_product), 32'd0);
  endtask

  task automatic run_op(input vec_t v, input int id);
    int n;
    int s0;
    out_ready = 1'b1;
    in_a = v.a;
    in_b = v.b;
    in_valid = 1'b1;
    s0 = n_starts;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("op%0d_latency", id), 32'(n), 32'(v.lat));
    chk($sformatf("op%0d_product", id), 32'(out_product), 32'(v.prod));
    chk($sformatf("op%0d_start_cycles", id), 32'(n_starts - s0), 32'(v.starts));
    tick();
  endtask

  initial begin
    int   n, s0, acc0, r0, ov0;
    logic stable;
    logic [15:0] p0;
    vec_t v;

    tbl[0] = '{a: 8'h03, b: 8'h05, prod: 16'h000F, lat: 11, starts: 1};
    tbl[1] = '{a: 8'hFD, b: 8'h07, prod: 16'hFFEB, lat: 11, starts: 1};
    tbl[2] = '{a: 8'h80, b: 8'h80, prod: 16'h4000, lat: 11, starts: 1};
    tbl[3] = '{a: 8'h7F, b: 8'h80, prod: 16'hC080, lat: 11, starts: 1};
    tbl[4] = '{a: 8'hFF, b: 8'h01, prod: 16'hFFFF, lat: 11, starts: 1};
`ifdef MULT_ISSUE_ZERO_SKIP_EN
    tbl[5] = '{a: 8'h00, b: 8'h09, prod: 16'h0000, lat: 2,  starts: 0};
`else
    tbl[5] = '{a: 8'h00, b: 8'h09, prod: 16'h0000, lat: 11, starts: 1};
`endif

    rst_n = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_op(tbl[i], i);

    // Fill with consumer stalled, then hold backpressure, then drain.
    out_ready = 1'b0;
    acc0 = n_acc;
    r0 = n_res;
    for (int j = 0; j < 5; j++) begin
      in_a = 8'($urandom_range(1, 255));
      in_b = 8'($urandom_range(1, 255));
      in_valid = 1'b1;
      tick();
    end
    in_a = 8'($urandom_range(1, 255));
    in_b = 8'($urandom_range(1, 255));
    #1;
    chk("fill_in_ready_6th", 32'(in_ready), 32'd0);
    chk("fill_fifo_count", 32'(fifo_count), 32'd4);
    chk("fill_accepted", 32'(n_acc - acc0), 32'd5);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    p0 = out_product;
    s0 = n_starts;
    stable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (!out_valid || out_product !== p0) stable = 1'b0;
    end
    chk("bp_product_stable", 32'(stable), 32'd1);
    chk("bp_no_start", 32'(n_starts - s0), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while ((n_res - r0) < 6 && n < 300) begin
      tick();
      n++;
      if (n_acc - acc0 == 6) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("drain_result_count", 32'(n_res - r0), 32'd6);
    chk("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // Reset while the first op sits in WAIT with a second op queued.
    in_a = 8'h05;
    in_b = 8'h06;
    in_valid = 1'b1;
    tick();
    in_a = 8'h07;
    in_b = 8'h02;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset("midreset");
    rst_n = 1'b1;
    ov0 = n_ov;
    for (int j = 0; j < 25; j++) tick();
    chk("midreset_no_out_valid", 32'(n_ov - ov0), 32'd0);

    v = '{a: 8'hFF, b: 8'hFF, prod: 16'h0001, lat: 11, starts: 1};
    run_op(v, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
